// File: rtl/sram_bus_bridge_if.sv
// Signal bundle between the core's SRAM-style port, the bridge and the valid/ready memory bus.
// Handshake: a request transfers on a cycle with req_valid && req_ready. Once req_valid rises, it and every
// req_* field stay stable until that transfer. rsp_valid is a one-cycle pulse, one per accepted request.
interface sram_bus_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                cpu_en;
   logic [DATA_W/8-1:0] cpu_wen;
   logic [ADDR_W-1:0]   cpu_addr;
   logic [DATA_W-1:0]   cpu_wdata;
   logic                cpu_flush;
   logic [DATA_W-1:0]   cpu_rdata;
   logic                cpu_stall;
   logic                bus_err;
   logic                req_valid;
   logic                req_ready;
   logic                req_we;
   logic [DATA_W/8-1:0] req_be;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic                rsp_valid;
   logic [DATA_W-1:0]   rsp_data;

   // Bridge view.
   modport master (
      input  cpu_en, cpu_wen, cpu_addr, cpu_wdata, cpu_flush,
      input  req_ready, rsp_valid, rsp_data,
      output cpu_rdata, cpu_stall, bus_err,
      output req_valid, req_we, req_be, req_addr, req_wdata
   );

   // Core plus memory-fabric view.
   modport slave (
      output cpu_en, cpu_wen, cpu_addr, cpu_wdata, cpu_flush,
      output req_ready, rsp_valid, rsp_data,
      input  cpu_rdata, cpu_stall, bus_err,
      input  req_valid, req_we, req_be, req_addr, req_wdata
   );
endinterface

// File: rtl/sram_bus_bridge.sv
// Turns each single-cycle core SRAM access into one valid/ready bus transaction, stalling the core until
// the response returns; flushed accesses are completed on the bus but their response is dropped.
module sram_bus_bridge #(
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter int          TIMEOUT  = 0,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                clk,
   input  logic                rst,
   sram_bus_bridge_if.master   bus,
   output logic [1:0]          dbg_state
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W:0]    TMO_LIMIT = (CNT_W + 1)'(TIMEOUT);
   localparam logic [DATA_W-1:0] ERR_VAL   = DATA_W'(ERR_DATA);

   // dbg_state encoding: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   addr_q;
   logic [BE_W-1:0]     be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                discard;
   logic [CNT_W-1:0]    tmo_cnt;
   logic [CNT_W:0]      cnt_inc;

   logic launch;
   logic accept;
   logic kill;
   logic rsp_hit;
   logic tmo_hit;
   logic load_rsp;
   logic load_err;
   logic cnt_run;

   assign cnt_inc = {1'b0, tmo_cnt} + (CNT_W + 1)'(1);

   always_comb begin
      launch   = 1'b0;
      accept   = 1'b0;
      rsp_hit  = 1'b0;
      tmo_hit  = 1'b0;
      cnt_run  = 1'b0;
      // A flush in the same cycle as acceptance or response already counts as a kill.
      kill     = discard || bus.cpu_flush;
      state_next = state;
      unique case (state)
         IDLE: begin
            launch = bus.cpu_en && !bus.cpu_flush;
            if (launch) state_next = REQ;
         end
         REQ: begin
            accept = bus.req_ready;
            if (accept) state_next = WAIT;
         end
         WAIT: begin
            rsp_hit = bus.rsp_valid;
            tmo_hit = (TIMEOUT > 0) && !bus.rsp_valid && (cnt_inc == TMO_LIMIT);
            cnt_run = (TIMEOUT > 0) && ({1'b0, tmo_cnt} != TMO_LIMIT);
            if (rsp_hit || tmo_hit) state_next = kill ? IDLE : DONE;
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      load_rsp = rsp_hit && !kill;
      load_err = tmo_hit && !kill;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         discard <= 1'b0;
      end else if (launch) begin
         addr_q  <= bus.cpu_addr;
         be_q    <= bus.cpu_wen;
         wdata_q <= bus.cpu_wdata;
         we_q    <= |bus.cpu_wen;
         discard <= 1'b0;
      end else if ((state == REQ || state == WAIT) && bus.cpu_flush) begin
         discard <= 1'b1;
      end
   end

   // Counter saturates at TIMEOUT so it can never wrap back into range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (accept) begin
         tmo_cnt <= '0;
      end else if (cnt_run) begin
         tmo_cnt <= cnt_inc[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= load_err;
         if (load_rsp) begin
            rdata_q <= bus.rsp_data;
         end else if (load_err) begin
            rdata_q <= ERR_VAL;
         end
      end
   end

   assign bus.req_valid = (state == REQ);
   assign bus.req_addr  = addr_q;
   assign bus.req_be    = be_q;
   assign bus.req_wdata = wdata_q;
   assign bus.req_we    = we_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.bus_err   = err_q;
   assign bus.cpu_stall = ((state == IDLE) && bus.cpu_en && !bus.cpu_flush) ||
                          (state == REQ) || (state == WAIT);
   assign dbg_state     = state;
endmodule
